// File: rtl/systolic_pkg.sv
// Shared sizing constants and the accumulator-to-result saturation helper
// for the output-stationary systolic array.
package systolic_pkg;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int ACCW = 20;
  localparam int CW   = 16;
  localparam int K    = 4;

  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((2 ** (CW - 1)) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-(2 ** (CW - 1)));

  function automatic logic signed [CW-1:0] sat_cw(input logic signed [ACCW-1:0] v);
    if (v > SAT_MAX)      return CW'(SAT_MAX);
    else if (v < SAT_MIN) return CW'(SAT_MIN);
    else                  return CW'(v);
  endfunction
endpackage

// File: rtl/systolic_pe.sv
// One MAC cell: accumulates a*b when both incoming valids are set and
// forwards row data east / column data south through one register each.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DW   = systolic_pkg::DW,
  parameter int ACCW = systolic_pkg::ACCW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic signed [DW-1:0]   a_i,
  input  logic                   a_v_i,
  input  logic signed [DW-1:0]   b_i,
  input  logic                   b_v_i,
  output logic signed [DW-1:0]   a_o,
  output logic                   a_v_o,
  output logic signed [DW-1:0]   b_o,
  output logic                   b_v_o,
  output logic signed [ACCW-1:0] acc_o
);
  logic signed [DW-1:0]   a_q, a_d, b_q, b_d;
  logic                   a_v_q, a_v_d, b_v_q, b_v_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [2*DW-1:0] prod;

  assign prod = (2*DW)'(a_i) * (2*DW)'(b_i);

  // clr only touches the accumulator; the data/valid pipeline keeps flowing
  always_comb begin
    a_d   = a_i;
    a_v_d = a_v_i;
    b_d   = b_i;
    b_v_d = b_v_i;
    acc_d = acc_q;
    if (clr)                acc_d = '0;
    else if (a_v_i && b_v_i) acc_d = acc_q + ACCW'(prod);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      a_v_q <= 1'b0;
      b_q   <= '0;
      b_v_q <= 1'b0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      a_v_q <= a_v_d;
      b_q   <= b_d;
      b_v_q <= b_v_d;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign a_v_o = a_v_q;
  assign b_o   = b_q;
  assign b_v_o = b_v_q;
  assign acc_o = acc_q;
endmodule

// File: rtl/systolic_array_4x4.sv
// N x N output-stationary systolic multiplier: skewed rows enter on the left,
// skewed columns on top; done latches when the corner PE's stream ends.
module systolic_array_4x4
  import systolic_pkg::*;
#(
  parameter int N    = systolic_pkg::N,
  parameter int DW   = systolic_pkg::DW,
  parameter int ACCW = systolic_pkg::ACCW,
  parameter int CW   = systolic_pkg::CW,
  parameter int K    = systolic_pkg::K
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [N*DW-1:0]   a_left_flat,
  input  logic [N-1:0]      a_v_row_flat,
  input  logic [N*DW-1:0]   b_top_flat,
  input  logic [N-1:0]      b_v_col_flat,
  output logic [N*N*CW-1:0] C_flat,
  output logic              done
);
  // a_w[i][j] / b_w[i][j] are the operands arriving at PE(i,j); index N is the far edge
  logic [N-1:0][N:0][DW-1:0]     a_w;
  logic [N-1:0][N:0]             av_w;
  logic [N:0][N-1:0][DW-1:0]     b_w;
  logic [N:0][N-1:0]             bv_w;
  logic [N-1:0][N-1:0][ACCW-1:0] acc_w;
  logic [N-1:0][DW:0]            east_unused;
  logic [N-1:0][DW:0]            south_unused;

  for (genvar i = 0; i < N; i++) begin : g_edge
    assign a_w[i][0]       = a_left_flat[i*DW +: DW];
    assign av_w[i][0]      = a_v_row_flat[i];
    assign b_w[0][i]       = b_top_flat[i*DW +: DW];
    assign bv_w[0][i]      = b_v_col_flat[i];
    assign east_unused[i]  = {av_w[i][N], a_w[i][N]};
    assign south_unused[i] = {bv_w[N][i], b_w[N][i]};
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe #(.DW(DW), .ACCW(ACCW)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .a_i   (a_w[i][j]),
        .a_v_i (av_w[i][j]),
        .b_i   (b_w[i][j]),
        .b_v_i (bv_w[i][j]),
        .a_o   (a_w[i][j+1]),
        .a_v_o (av_w[i][j+1]),
        .b_o   (b_w[i+1][j]),
        .b_v_o (bv_w[i+1][j]),
        .acc_o (acc_w[i][j])
      );
      assign C_flat[(i*N+j)*CW +: CW] = sat_cw(acc_w[i][j]);
    end
  end

  logic last_v;
  logic last_v_q, last_v_d;
  logic done_q, done_d;

  assign last_v = av_w[N-1][N-1] & bv_w[N-1][N-1];

  always_comb begin
    last_v_d = last_v;
    done_d   = done_q | (last_v_q & ~last_v);
    if (clr) done_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_v_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      last_v_q <= last_v_d;
      done_q   <= done_d;
    end
  end

  assign done = done_q;
endmodule

// File: tb/tb_systolic_array_4x4.sv
// Directed bench for systolic_array_4x4: expected matrices are queued when a
// stream is launched and checked against C_flat once done rises.
module tb_systolic_array_4x4;
  typedef int mat_t [4][4];

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clr = 1'b0;
  logic [31:0]  a_left_flat = '0;
  logic [3:0]   a_v_row_flat = '0;
  logic [31:0]  b_top_flat = '0;
  logic [3:0]   b_v_col_flat = '0;
  logic [255:0] C_flat;
  logic         done;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  mat_t A_REF = '{'{1,2,3,4}, '{5,6,7,8}, '{2,4,6,8}, '{1,3,5,7}};
  mat_t B_REF = '{'{1,0,0,1}, '{0,1,0,1}, '{0,0,1,1}, '{1,1,1,2}};
  mat_t C_REF = '{'{5,6,7,14}, '{13,14,15,34}, '{10,12,14,28}, '{8,10,12,23}};
  mat_t ID    = '{'{1,0,0,0}, '{0,1,0,0}, '{0,0,1,0}, '{0,0,0,1}};

  always #5 clk = ~clk;

  systolic_array_4x4 #(.N(4), .DW(8), .ACCW(20), .CW(16), .K(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .a_left_flat  (a_left_flat),
    .a_v_row_flat (a_v_row_flat),
    .b_top_flat   (b_top_flat),
    .b_v_col_flat (b_v_col_flat),
    .C_flat       (C_flat),
    .done         (done)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic mat_t mmul(input mat_t a, input mat_t b);
    mat_t r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        int s = 0;
        for (int k = 0; k < 4; k++) s += a[i][k] * b[k][j];
        r[i][j] = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
      end
    return r;
  endfunction

  function automatic mat_t fill(input int v);
    mat_t r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) r[i][j] = v;
    return r;
  endfunction

  task automatic push_m(input mat_t m);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) exp_q.push_back(m[i][j]);
  endtask

  task automatic cmp_c(input string tag);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL %s_c%0d%0d observed=no_expected_entry expected=queued_value", tag, i, j);
        end else begin
          chk($sformatf("%s_c%0d%0d", tag, i, j), $signed(C_flat[(i*4+j)*16 +: 16]), exp_q.pop_front());
        end
      end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_c%0d", tag, i), $signed(C_flat[i*16 +: 16]), 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
  endtask

  // Priming cycle, then 8 skewed cycles with valids held high; abort>=0 stops early.
  task automatic stream(input mat_t a, input mat_t b, input logic [3:0] rmask, input int abort);
    @(negedge clk);
    a_left_flat = '0; b_top_flat = '0; a_v_row_flat = '0; b_v_col_flat = '0;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      if (s == abort) return;
      for (int i = 0; i < 4; i++) begin
        int k = s - i;
        a_left_flat[i*8 +: 8] = (k >= 0 && k < 4) ? 8'(a[i][k]) : 8'd0;
        b_top_flat[i*8 +: 8]  = (k >= 0 && k < 4) ? 8'(b[k][i]) : 8'd0;
      end
      a_v_row_flat = rmask;
      b_v_col_flat = 4'hF;
    end
    @(negedge clk);
    a_left_flat = '0; b_top_flat = '0; a_v_row_flat = '0; b_v_col_flat = '0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, {31'd0, done}, 1);
  endtask

  task automatic do_clr();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  initial begin
    mat_t ar, br, cg;

    #12;
    check_zero("reset");
    @(negedge clk) rst = 1'b1;

    push_m(C_REF);
    stream(A_REF, B_REF, 4'hF, -1);
    wait_done("ref");
    cmp_c("ref");

    // corner PE sees valid through edge 10 of the stream, so done lands on edge 11
    do_clr();
    push_m(mmul(A_REF, ID));
    stream(A_REF, ID, 4'hF, -1);
    repeat (3) @(negedge clk);
    chk("id_done_early", {31'd0, done}, 0);
    @(negedge clk);
    chk("id_done_edge", {31'd0, done}, 1);
    cmp_c("ident");

    do_clr();
    push_m(fill(32767));
    stream(fill(127), fill(127), 4'hF, -1);
    wait_done("satp");
    cmp_c("satp");

    do_clr();
    push_m(fill(-32768));
    stream(fill(-128), fill(127), 4'hF, -1);
    wait_done("satn");
    cmp_c("satn");

    do_clr();
    check_zero("clr");
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ar[i][j] = int'($urandom_range(0, 40)) - 20;
        br[i][j] = int'($urandom_range(0, 40)) - 20;
      end
    push_m(mmul(ar, br));
    stream(ar, br, 4'hF, -1);
    wait_done("rand");
    cmp_c("rand");

    // no clr: done is still set and partial sums pile up before the async reset
    stream(A_REF, B_REF, 4'hF, 4);
    #2 rst = 1'b0;
    #1 check_zero("async_rst");
    a_left_flat = '0; b_top_flat = '0; a_v_row_flat = '0; b_v_col_flat = '0;
    @(negedge clk) rst = 1'b1;
    push_m(C_REF);
    stream(A_REF, B_REF, 4'hF, -1);
    wait_done("restream");
    cmp_c("restream");

    do_clr();
    cg = C_REF;
    for (int j = 0; j < 4; j++) cg[2][j] = 0;
    push_m(cg);
    stream(A_REF, B_REF, 4'b1011, -1);
    wait_done("gate");
    cmp_c("gate");

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/systolic_array_4x4.md
SYSTOLIC_ARRAY_4X4 -- requirements
Module: systolic_array_4x4

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
  N 4 array rows/columns
  DW 8 signed operand width
  ACCW 20 signed accumulator width
  CW 16 signed result width
  K 4 inner dimension (informational; no logic depends on it)
REQ-002 Ports (name, direction, width, meaning) SHALL be:
  clk  in  1  single clock, rising edge
  rst  in  1  asynchronous, active-low reset
  clr  in  1  synchronous clear of accumulators and done
  a_left_flat  in  N*DW  row i operand at bits [i*DW +: DW], signed
  a_v_row_flat  in  N  row i operand valid at bit i
  b_top_flat  in  N*DW  column j operand at bits [j*DW +: DW], signed
  b_v_col_flat  in  N  column j operand valid at bit j
  C_flat  out  N*N*CW  C[i][j] at bits [(i*N+j)*CW +: CW], signed
  done  out  1  result-complete flag, sticky

Function
REQ-003 The block SHALL be an output-stationary N x N grid; PE(i,j) holds one accumulator.
REQ-004 Row-i data and valid SHALL enter PE(i,0) and be registered one cycle per PE moving right; column-j data and valid SHALL enter PE(0,j) and be registered one cycle per PE moving down.
REQ-005 PE(i,j) therefore SHALL see row-i input delayed j cycles and column-j input delayed i cycles.
REQ-006 On each rising edge where both of a PE's incoming valids are 1, acc SHALL be updated to acc + sign_extend_ACCW(a*b), with a*b a full 2*DW signed product; otherwise acc SHALL hold.
REQ-007 Zero-valued operands with valid=1 SHALL be accumulated normally, contributing 0.
REQ-008 The caller SHALL skew inputs: A[i][k] on row i and B[k][j] on column j, both at stream cycle k+i and k+j respectively, so they meet in PE(i,j) at cycle k+i+j.
REQ-009 C[i][j] SHALL be combinationally derived from acc, saturated to the signed CW range [-32768, 32767].
REQ-010 done SHALL be set on the edge following the cycle in which PE(N-1,N-1)'s combined valid (row AND column) falls from 1 to 0; it SHALL remain 1 until rst or clr.
REQ-011 If the combined valid never falls, done SHALL stay 0.
REQ-012 clr=1 SHALL zero all accumulators and done on the next edge, taking priority over accumulation that cycle; pipeline registers SHALL be unaffected by clr.
REQ-013 Accumulator overflow beyond ACCW SHALL wrap (two's complement); ACCW=20 is sized for K=4 full-scale products.

Reset
REQ-014 While rst=0, all accumulators, pipeline data/valid registers and done SHALL be 0 asynchronously, so C_flat=0 and done=0.
REQ-015 Reset asserted mid-stream SHALL discard partial sums; operation resumes from zero after release.

Structure
REQ-016 N, DW, ACCW, CW and the saturation helper SHALL live in a shared package (systolic_pkg).
REQ-017 One sub-module, systolic_pe, SHALL implement a single MAC cell with data/valid pass-through registers; the top SHALL instantiate N*N of them via generate plus the done logic.

Verification
REQ-018 Reference multiply: A=[1 2 3 4;5 6 7 8;2 4 6 8;1 3 5 7], B=[1 0 0 1;0 1 0 1;0 0 1 1;1 1 1 2] streamed skewed (1 priming cycle, then K+N cycles, valids=1 throughout) -> after done, C=[5 6 7 14;13 14 15 34;10 12 14 28;8 10 12 23].
REQ-019 Identity: B=I, same A -> C=A; done rises one edge after PE(3,3) valid falls.
REQ-020 Saturation: all A=127, all B=127 -> every C=32767; all A=-128, all B=127 -> every C=-32768.
REQ-021 clr after a completed multiply -> next edge all C=0, done=0; a second multiply then yields correct results with no residue.
REQ-022 rst driven low mid-stream -> C_flat=0 and done=0 immediately, without waiting for a clock edge; a full restream after release yields REQ-018 results.
REQ-023 Valid gating: hold a_v_row_flat[2]=0 during streaming -> row 2 of C stays 0, other rows as in REQ-018.
